// File: rtl/apb_resp_mux.sv
// APB response multiplexer: routes the selected slave's PRDATA/PREADY/PSLVERR back to the bridge.
// Define APB_RESP_MUX_TIMEOUT_EN to force an error response on slaves stalled for TIMEOUT_CYCLES.
module apb_resp_mux #(
    parameter int NUM_SLV        = 12,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                          PCLK,
    input  logic                          PRESETn,
    input  logic [NUM_SLV-1:0]            psel,
    input  logic                          penable,
    input  logic [NUM_SLV*DATA_WIDTH-1:0] prdata_vec,
    input  logic [NUM_SLV-1:0]            pready_vec,
    input  logic [NUM_SLV-1:0]            pslverr_vec,
    input  logic                          clr_err,
    output logic [DATA_WIDTH-1:0]         prdata,
    output logic                          pready,
    output logic                          pslverr,
    output logic [1:0]                    err_status
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    if (NUM_SLV < 1 || NUM_SLV > 32) begin : g_bad_num_slv
        $error("apb_resp_mux: NUM_SLV must be 1..32");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("apb_resp_mux: TIMEOUT_CYCLES must be >= 2");
    end

    state_t                state;
    logic [NUM_SLV-1:0]    sel_q;
    logic [DATA_WIDTH-1:0] slv_data;
    logic                  slv_ready;
    logic                  slv_err;
    logic                  multi_hot;
    logic                  timeout;
    logic                  in_access;

    assign in_access = (state == ACCESS);
    assign multi_hot = |(sel_q & (sel_q - NUM_SLV'(1)));

    // OR-reduction mux is exact for a one-hot select; multi-hot is overridden below.
    always_comb begin
        slv_data  = '0;
        slv_ready = 1'b0;
        slv_err   = 1'b0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (sel_q[i]) begin
                slv_data  = slv_data | prdata_vec[i*DATA_WIDTH +: DATA_WIDTH];
                slv_ready = slv_ready | pready_vec[i];
                slv_err   = slv_err | pslverr_vec[i];
            end
        end
    end

`ifdef APB_RESP_MUX_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] cnt;

    // A slave that becomes ready in the last allowed cycle still completes normally.
    assign timeout = in_access && !multi_hot && !slv_ready && (cnt == CNT_LAST);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cnt <= '0;
        end else if (state == SETUP) begin
            cnt <= '0;
        end else if (in_access && !pready && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Combinational response path: no added latency on PREADY.
    always_comb begin
        prdata  = '0;
        pready  = 1'b0;
        pslverr = 1'b0;
        if (in_access) begin
            if (multi_hot || timeout) begin
                pready  = 1'b1;
                pslverr = 1'b1;
            end else begin
                prdata  = slv_data;
                pready  = slv_ready;
                pslverr = slv_err;
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state <= IDLE;
            sel_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|psel && !penable) state <= SETUP;
                end
                SETUP: begin
                    sel_q <= psel;
                    state <= ACCESS;
                end
                ACCESS: begin
                    if (pready) state <= (|psel) ? SETUP : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Set-dominant sticky flags: a new error on the clearing edge survives.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            err_status <= 2'b00;
        end else begin
            err_status <= (clr_err ? 2'b00 : err_status) | {timeout, in_access && multi_hot};
        end
    end

endmodule

// File: tb/tb_apb_resp_mux.sv
// Scoreboard bench for apb_resp_mux: directed reads push expected responses, a monitor pops on pready.
module tb_apb_resp_mux;

    localparam int NS = 12;
    localparam int DW = 32;
    localparam int TC = 4;

    logic              PCLK;
    logic              PRESETn;
    logic [NS-1:0]     psel;
    logic              penable;
    logic [NS*DW-1:0]  prdata_vec;
    logic [NS-1:0]     pready_vec;
    logic [NS-1:0]     pslverr_vec;
    logic              clr_err;
    logic [DW-1:0]     prdata;
    logic              pready;
    logic              pslverr;
    logic [1:0]        err_status;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    logic seen;

    apb_resp_mux #(.NUM_SLV(NS), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TC)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .psel(psel), .penable(penable),
        .prdata_vec(prdata_vec), .pready_vec(pready_vec), .pslverr_vec(pslverr_vec),
        .clr_err(clr_err), .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .err_status(err_status)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge PCLK);
        #1;
    endtask

    task automatic sample;
        @(negedge PCLK);
    endtask

    // Drive SETUP then ACCESS from the bridge; returns in FSM ACCESS cycle 1.
    task automatic start(input logic [NS-1:0] sel);
        psel = sel;
        penable = 1'b0;
        tick();
        penable = 1'b1;
        tick();
    endtask

    task automatic end_xfer;
        psel = '0;
        penable = 1'b0;
        tick();
        pready_vec = '0;
        pslverr_vec = '0;
    endtask

    task automatic clear_err;
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
    endtask

    // Monitor: every completed response must match the oldest expectation.
    always @(negedge PCLK) begin
        if (PRESETn === 1'b1 && pready === 1'b1) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_pready", 64'(pready), 64'(0));
            end else begin
                mon_e = sb.pop_front();
                check("sb_prdata", 64'(prdata), 64'(mon_e.data));
                check("sb_pslverr", 64'(pslverr), 64'(mon_e.err));
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        PRESETn = 1'b0;
        psel = '0;
        penable = 1'b0;
        prdata_vec = '0;
        pready_vec = '0;
        pslverr_vec = '0;
        clr_err = 1'b0;
        #1;
        check("rst_pready", 64'(pready), 64'(0));
        check("rst_prdata", 64'(prdata), 64'(0));
        check("rst_err_status", 64'(err_status), 64'(0));
        #11 PRESETn = 1'b1;
        tick();

        // Slave 2 with two wait states.
        prdata_vec[2*DW +: DW] = 32'hCAFE_0002;
        sb.push_back('{data: 32'hCAFE_0002, err: 1'b0});
        start(12'h004);
        sample(); check("wait_c1_pready", 64'(pready), 64'(0)); tick();
        sample(); check("wait_c2_pready", 64'(pready), 64'(0)); tick();
        pready_vec[2] = 1'b1;
        sample();
        check("wait_c3_pready", 64'(pready), 64'(1));
        check("wait_c3_prdata", 64'(prdata), 64'(32'hCAFE_0002));
        end_xfer();

        // Back-to-back: slave 0 then slave 11 with no IDLE between.
        prdata_vec[0*DW +: DW] = 32'hA000_0000;
        prdata_vec[11*DW +: DW] = 32'hB000_000B;
        pready_vec = 12'h001;
        sb.push_back('{data: 32'hA000_0000, err: 1'b0});
        start(12'h001);
        psel = 12'h800;
        penable = 1'b0;
        sample();
        check("b2b_first_prdata", 64'(prdata), 64'(32'hA000_0000));
        tick();
        sample(); check("b2b_setup_pready", 64'(pready), 64'(0));
        penable = 1'b1;
        pready_vec = 12'h800;
        sb.push_back('{data: 32'hB000_000B, err: 1'b0});
        tick();
        sample();
        check("b2b_second_pready", 64'(pready), 64'(1));
        check("b2b_second_prdata", 64'(prdata), 64'(32'hB000_000B));
        end_xfer();

        // Multi-hot select answered with an error in the first ACCESS cycle.
        prdata_vec[1*DW +: DW] = 32'h1111_0001;
        sb.push_back('{data: 32'h0, err: 1'b1});
        start(12'h003);
        sample();
        check("mh_pready", 64'(pready), 64'(1));
        check("mh_err_before_edge", 64'(err_status), 64'(0));
        end_xfer();
        check("mh_err_status", 64'(err_status), 64'(2'b01));
        clear_err();
        check("mh_cleared", 64'(err_status), 64'(2'b00));

        // Slave error passes through without flagging.
        prdata_vec[5*DW +: DW] = 32'h5555_0005;
        pready_vec[5] = 1'b1;
        pslverr_vec[5] = 1'b1;
        sb.push_back('{data: 32'h5555_0005, err: 1'b1});
        start(12'h020);
        sample();
        check("slverr_pslverr", 64'(pslverr), 64'(1));
        end_xfer();
        check("slverr_no_flag", 64'(err_status), 64'(2'b00));

        // Slave 8 ready exactly in ACCESS cycle TC: normal response.
        prdata_vec[8*DW +: DW] = 32'h8888_0008;
        start(12'h100);
        for (int c = 1; c < TC; c++) begin
            sample(); check("late_wait_pready", 64'(pready), 64'(0)); tick();
        end
        pready_vec[8] = 1'b1;
        sb.push_back('{data: 32'h8888_0008, err: 1'b0});
        sample();
        check("late_pready", 64'(pready), 64'(1));
        end_xfer();
        check("late_no_flag", 64'(err_status), 64'(2'b00));

        // Slave 8 never ready.
        start(12'h100);
`ifdef APB_RESP_MUX_TIMEOUT_EN
        sb.push_back('{data: 32'h0, err: 1'b1});
        for (int c = 1; c < TC; c++) begin
            sample(); check("to_wait_pready", 64'(pready), 64'(0)); tick();
        end
        sample();
        check("to_pready", 64'(pready), 64'(1));
        check("to_pslverr", 64'(pslverr), 64'(1));
        check("to_prdata", 64'(prdata), 64'(0));
        end_xfer();
        check("to_err_status", 64'(err_status), 64'(2'b10));
        clear_err();
        check("to_cleared", 64'(err_status), 64'(2'b00));
`else
        seen = 1'b0;
        repeat (100) begin
            sample();
            if (pready === 1'b1) seen = 1'b1;
            tick();
        end
        check("no_timeout_pready", 64'(seen), 64'(0));
        pready_vec[8] = 1'b1;
        sb.push_back('{data: 32'h8888_0008, err: 1'b0});
        sample();
        check("stall_release_pready", 64'(pready), 64'(1));
        end_xfer();
        check("stall_no_flag", 64'(err_status), 64'(2'b00));
`endif

        // Set-dominant: clr_err on the same edge as a new multi-hot error.
        sb.push_back('{data: 32'h0, err: 1'b1});
        start(12'h003);
        clr_err = 1'b1;
        sample();
        end_xfer();
        clr_err = 1'b0;
        check("setdom_err_status", 64'(err_status), 64'(2'b01));

        // Asynchronous reset in the middle of a stalled ACCESS.
        prdata_vec[2*DW +: DW] = 32'hDEAD_0002;
        pslverr_vec[2] = 1'b1;
        start(12'h004);
        sample();
        check("pre_rst_pslverr", 64'(pslverr), 64'(1));
        #2 PRESETn = 1'b0;
        #1;
        check("arst_prdata", 64'(prdata), 64'(0));
        check("arst_pslverr", 64'(pslverr), 64'(0));
        check("arst_err_status", 64'(err_status), 64'(0));
        pready_vec[2] = 1'b1;
        tick();
        #3 PRESETn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            sample(); check("post_rst_idle_pready", 64'(pready), 64'(0));
        end
        end_xfer();

        tick();
        check("sb_drained", 64'(sb.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
